// File: rtl/present80_key_schedule_if.sv
// Key-schedule port bundle: the master loads keys and requests rounds, the slave
// presents the current round key and its status flags.
interface present80_key_schedule_if;
  // Handshake: key_load and round_adv are single-cycle strobes taken on the rising
  // clock edge with no back-pressure. key_load wins when both are high. round_adv
  // is only accepted while a key is presented that is not K32. Every output is a
  // registered value and is stable for the whole cycle after the edge.
  logic        key_load;
  logic [79:0] key_in;
  logic        round_adv;
  logic [79:0] round_key;
  logic [4:0]  round_cnt;
  logic        key_valid;
  logic        last_key;
  logic [1:0]  state;

  modport master (
    output key_load, key_in, round_adv,
    input  round_key, round_cnt, key_valid, last_key, state
  );

  modport slave (
    input  key_load, key_in, round_adv,
    output round_key, round_cnt, key_valid, last_key, state
  );
endinterface

// File: rtl/present80_key_schedule.sv
// PRESENT-80 round-key generator: holds one 80-bit key register and steps it
// through K1..K32, one key per accepted round_adv strobe.
module present80_key_schedule (
  input logic                       clk,
  input logic                       rst_n,
  present80_key_schedule_if.slave   ks
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
  localparam logic [4:0] CNT_LAST  = 5'd31;

  logic [1:0]  state_q, state_d;
  logic [79:0] key_q, key_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic [79:0] rot_key;
  logic [79:0] step_key;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  // One schedule step: rotate left by 61, S-box the top nibble, mix in the round index.
  always_comb begin
    rot_key          = {key_q[18:0], key_q[79:19]};
    step_key         = rot_key;
    step_key[79:76]  = sbox(rot_key[79:76]);
    step_key[19:15]  = rot_key[19:15] ^ cnt_q;
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (ks.key_load) begin
      // A load restarts the schedule from any state and drops a coincident advance.
      state_d = ST_ACTIVE;
      key_d   = ks.key_in;
      cnt_d   = 5'd1;
      valid_d = 1'b1;
      last_d  = 1'b0;
    end else if (ks.round_adv && (state_q == ST_ACTIVE)) begin
      key_d = step_key;
      if (cnt_q == CNT_LAST) begin
        // K32 keeps the counter at 31; there is no index 32.
        state_d = ST_DONE;
        last_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign ks.round_key = key_q;
  assign ks.round_cnt = cnt_q;
  assign ks.key_valid = valid_q;
  assign ks.last_key  = last_q;
  assign ks.state     = state_q;

endmodule

// File: tb/tb_present80_key_schedule.sv
// Directed-plus-random bench for present80_key_schedule against an arithmetic
// PRESENT-80 key-schedule model.
module tb_present80_key_schedule;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  logic [79:0] exp_q[$];
  logic [3:0]  sbox_tbl [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                 4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  present80_key_schedule_if ks_if ();

  present80_key_schedule dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ks    (ks_if)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [79:0] model_next(input logic [79:0] k, input int i);
    logic [79:0] r;
    logic [79:0] one_nib;
    int          top;
    one_nib = 80'hF;
    r   = (k << 61) | (k >> 19);
    top = int'(r >> 76);
    r   = (r & ~(one_nib << 76)) | (80'(sbox_tbl[top]) << 76);
    r   = r ^ (80'(i) << 15);
    return r;
  endfunction

  task automatic build_schedule(input logic [79:0] master);
    logic [79:0] k;
    exp_q.delete();
    k = master;
    for (int i = 1; i <= 31; i++) begin
      exp_q.push_back(k);
      k = model_next(k, i);
    end
    exp_q.push_back(k);
  endtask

  function automatic logic [79:0] rand_key();
    return {$urandom(), $urandom(), 16'($urandom())};
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [79:0] k, input int cnt,
                           input logic valid, input logic last);
    check({tag, ".key"},   ks_if.round_key,        k);
    check({tag, ".cnt"},   80'(ks_if.round_cnt),   80'(cnt));
    check({tag, ".valid"}, 80'(ks_if.key_valid),   80'(valid));
    check({tag, ".last"},  80'(ks_if.last_key),    80'(last));
  endtask

  // ---------------- driver ----------------
  // Drive strobes for exactly one rising edge, then sample 1 time unit after it.
  task automatic tick(input logic load, input logic [79:0] key, input logic adv);
    @(negedge clk);
    ks_if.key_load  = load;
    ks_if.key_in    = key;
    ks_if.round_adv = adv;
    @(posedge clk);
    #1;
    ks_if.key_load  = 1'b0;
    ks_if.round_adv = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [79:0] k_a;
    logic [79:0] k_b;
    logic [79:0] cur;
    n_cmp = 0;
    n_bad = 0;
    ks_if.key_load  = 1'b0;
    ks_if.key_in    = '0;
    ks_if.round_adv = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_out("reset", 80'h0, 0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Advance with no key loaded is ignored.
    tick(1'b0, 80'h0, 1'b1);
    check_out("idle_adv", 80'h0, 0, 1'b0, 1'b0);

    // Zero-key and all-ones single steps.
    tick(1'b1, 80'h0, 1'b0);
    check_out("zero_load", 80'h0, 1, 1'b1, 1'b0);
    tick(1'b0, 80'h0, 1'b1);
    check_out("zero_step", 80'hC0000000000000008000, 2, 1'b1, 1'b0);
    tick(1'b1, 80'hFFFFFFFFFFFFFFFFFFFF, 1'b0);
    tick(1'b0, 80'h0, 1'b1);
    check_out("ones_step", 80'h2FFFFFFFFFFFFFFF7FFF, 2, 1'b1, 1'b0);

    // Full schedule with random idle gaps between strobes.
    k_a = rand_key();
    build_schedule(k_a);
    tick(1'b1, k_a, 1'b0);
    cur = exp_q.pop_front();
    check_out("full_k1", cur, 1, 1'b1, 1'b0);
    for (int r = 2; r <= 32; r++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        tick(1'b0, 80'h0, 1'b0);
        check("full_gap.key", ks_if.round_key, cur);
      end
      tick(1'b0, 80'h0, 1'b1);
      cur = exp_q.pop_front();
      check_out($sformatf("full_k%0d", r), cur, (r == 32) ? 31 : r, 1'b1, r == 32);
    end
    tick(1'b0, 80'h0, 1'b1);
    check_out("done_adv", cur, 31, 1'b1, 1'b1);

    // Load from DONE restarts at K1 with no idle cycle.
    k_b = rand_key();
    tick(1'b1, k_b, 1'b0);
    check_out("done_reload", k_b, 1, 1'b1, 1'b0);

    // Load colliding with advance at round 10.
    build_schedule(k_b);
    void'(exp_q.pop_front());
    for (int r = 2; r <= 10; r++) begin
      tick(1'b0, 80'h0, 1'b1);
      cur = exp_q.pop_front();
    end
    check_out("coll_pre", cur, 10, 1'b1, 1'b0);
    k_a = rand_key();
    tick(1'b1, k_a, 1'b1);
    check_out("collision", k_a, 1, 1'b1, 1'b0);
    tick(1'b0, 80'h0, 1'b1);
    check_out("coll_next", model_next(k_a, 1), 2, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a schedule.
    tick(1'b1, rand_key(), 1'b0);
    for (int r = 2; r <= 17; r++) tick(1'b0, 80'h0, 1'b1);
    check("mid_cnt", 80'(ks_if.round_cnt), 80'd17);
    #2 rst_n = 1'b0;
    #1 check_out("async_rst", 80'h0, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0, 80'h0, 1'b1);
    check_out("post_rst_adv", 80'h0, 0, 1'b0, 1'b0);
    tick(1'b0, 80'h0, 1'b1);
    check_out("post_rst_adv2", 80'h0, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog keeps the run bounded even if the stimulus stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/present80_key_schedule.md
PRESENT80_KEY_SCHEDULE -- requirements
Module: present80_key_schedule

Interface
REQ-001 SHALL have no parameters; key width 80 and round count 31 are fixed constants.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 key_load  input  1  single-cycle strobe; capture key_in as the master key.
REQ-005 key_in  input  80  master key; sampled only when key_load=1.
REQ-006 round_adv  input  1  strobe; derive the next round key.
REQ-007 round_key  output  80  current key register; the add-round-key stage XORs round_key[79:16] into the state.
REQ-008 round_cnt  output  5  index of the round key currently presented, 1..31; value 0 means no key is loaded.
REQ-009 key_valid  output  1  high while round_key holds a loaded or derived key.
REQ-010 last_key  output  1  high while round_key holds K32, the final whitening key.

Function
REQ-011 SHALL implement three states: IDLE (no key), ACTIVE (K1..K31 presented) and DONE (K32 presented).
REQ-012 key_load=1 in any state SHALL load round_key<=key_in and round_cnt<=1, and SHALL enter ACTIVE on the next edge.
REQ-013 round_adv=1 in ACTIVE with key_load=0 SHALL perform one update step using i=round_cnt:
- rotate the 80-bit register left by 61;
- replace bits [79:76] with S(bits [79:76]);
- XOR bits [19:15] with i[4:0].
REQ-014 The S-box SHALL be the PRESENT 4-bit S-box, 0..F -> C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
REQ-015 Each accepted round_adv SHALL increment round_cnt by 1. The update SHALL have a latency of exactly one cycle: the new key is visible on the edge that accepts the strobe.
REQ-016 The advance with round_cnt=31 SHALL present K32 and enter DONE. In DONE, round_cnt SHALL hold 31 and last_key=1.
REQ-017 round_adv in IDLE or DONE SHALL be ignored; round_key and round_cnt SHALL be unchanged.
REQ-018 key_load and round_adv asserted in the same cycle: key_load SHALL win and round_adv SHALL be dropped.
REQ-019 key_load during ACTIVE or DONE SHALL abort the schedule and restart from K1 without any idle cycle.
REQ-020 key_valid SHALL be 1 in ACTIVE and DONE and 0 in IDLE. last_key SHALL be 1 only in DONE.
REQ-021 All outputs SHALL be driven directly from registers, with no combinational path from inputs to outputs.
REQ-022 The XOR in REQ-013 SHALL use the 5-bit counter with no wrap-around; round_cnt SHALL never exceed 31.

Reset
REQ-023 rst_n=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, round_key=0, round_cnt=0, key_valid=0 and last_key=0.
REQ-024 Reset asserted mid-schedule SHALL discard the key. After release, round_adv SHALL be ignored until a key_load.
REQ-025 A key_load coincident with the release edge of rst_n is not required to be captured. The bench SHALL apply key_load no earlier than one cycle after release.

Verification
REQ-026 Zero-key step: load key_in=0, then one round_adv -> round_key=0xC0000000000000008000, round_cnt=2, key_valid=1, last_key=0.
REQ-027 All-ones step: load key_in=0xFFFFFFFFFFFFFFFFFFFF, then one round_adv -> round_key=0x2FFFFFFFFFFFFFFF7FFF, round_cnt=2.
REQ-028 Full schedule: load, then 31 round_adv strobes (back-to-back and with gaps) -> all K1..K32 match a software PRESENT-80 model. After the 31st strobe last_key=1; a 32nd strobe leaves round_key unchanged.
REQ-029 Collision: key_load with round_adv in ACTIVE at round_cnt=10 -> next cycle round_key=key_in, round_cnt=1, and no update step is applied.
REQ-030 Reset mid-run: rst_n pulsed low at round_cnt=17 -> outputs zero asynchronously. round_adv after release -> outputs remain zero and key_valid=0.
REQ-031 Idle advance: round_adv after reset with no key loaded -> round_key=0, round_cnt=0, and state stays IDLE.
